// File: rtl/pipe_skid_buf_pkg.sv
// Shared pipeline defines: skid buffer state encoding
// and common pipeline constants.
package pipe_skid_buf_pkg;

  localparam int PIPE_XLEN  = 32;
  localparam int SKID_DEPTH = 2;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  typedef enum logic [1:0] {
    S_EMPTY = EMPTY,
    S_ONE   = ONE,
    S_FULL  = FULL
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf_if.sv
// Valid/ready bundle around the skid buffer.
// Optional flush signal exists only with SKID_FLUSH_EN.
interface pipe_skid_buf_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       count;
`ifdef SKID_FLUSH_EN
  logic             flush;

  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, count
  );
  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, count
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
`endif
endinterface

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer with fully registered in_ready/out_valid.
// Optional flush port enabled by macro SKID_FLUSH_EN.
module pipe_skid_buf
  import pipe_skid_buf_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
`ifdef SKID_FLUSH_EN
  ,
  input  logic             flush
`endif
);

  skid_state_e      r_state;
  skid_state_e      w_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [1:0]       r_count;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_main_d;
  logic             w_acc;
  logic             w_con;
  logic             w_main_en;
  logic             w_main_skid;
  logic             w_skid_en;

  assign w_acc = in_valid & r_in_ready;
  assign w_con = r_out_valid & out_ready;

  // Next state and register enables from the handshakes
  always_comb begin
    w_nxt       = r_state;
    w_main_en   = 1'b0;
    w_main_skid = 1'b0;
    w_skid_en   = 1'b0;
    unique case (r_state)
      S_EMPTY: begin
        if (w_acc) begin
          w_nxt     = S_ONE;
          w_main_en = 1'b1;
        end
      end
      S_ONE: begin
        if (w_acc && w_con) begin
          w_main_en = 1'b1;
        end else if (w_acc) begin
          w_nxt     = S_FULL;
          w_skid_en = 1'b1;
        end else if (w_con) begin
          w_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_con) begin
          w_nxt       = S_ONE;
          w_main_en   = 1'b1;
          w_main_skid = 1'b1;
        end
      end
      default: w_nxt = S_EMPTY;
    endcase
`ifdef SKID_FLUSH_EN
    if (flush) begin
      w_nxt       = S_EMPTY;
      w_main_en   = 1'b0;
      w_main_skid = 1'b0;
      w_skid_en   = 1'b0;
    end
`endif
  end

  assign w_main_d = w_main_skid ? r_skid : in_data;

  // State plus registered handshake flags and count
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_count     <= 2'd0;
    end else begin
      r_state     <= w_nxt;
      r_in_ready  <= (w_nxt != S_FULL);
      r_out_valid <= (w_nxt != S_EMPTY);
      r_count     <= w_nxt;
    end
  end

  // Main register: head beat, fed from input or skid
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_main <= '0;
    end else if (w_main_en) begin
      r_main <= w_main_d;
    end
  end

  // Skid register: catches the beat arriving while stalled
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_skid <= '0;
    end else if (w_skid_en) begin
      r_skid <= in_data;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;
  assign count     = r_count;

endmodule

// File: tb/tb_pipe_skid_buf.sv
// Directed and scoreboarded bench for pipe_skid_buf.
// Define SKID_FLUSH_EN to also exercise the flush path.
module tb_pipe_skid_buf;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  pipe_skid_buf_if #(.WIDTH(32)) bus ();

  pipe_skid_buf #(.WIDTH(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (bus.in_data),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (bus.out_data),
    .count     (bus.count)
`ifdef SKID_FLUSH_EN
    ,
    .flush     (bus.flush)
`endif
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_data = '0;
`ifdef SKID_FLUSH_EN
    bus.flush = 1'b0;
`endif
    #2;
    total_cnt++;
    if (bus.out_valid !== 1'b0) $display("FAIL rst_ovalid got %b want 0", bus.out_valid);
    else pass_cnt++;
    total_cnt++;
    if (bus.in_ready !== 1'b0) $display("FAIL rst_iready got %b want 0", bus.in_ready);
    else pass_cnt++;
    total_cnt++;
    if (bus.count !== 2'd0) $display("FAIL rst_count got %0d want 0", bus.count);
    else pass_cnt++;
    total_cnt++;
    if (bus.out_data !== 32'h0) $display("FAIL rst_odata got %h want 0", bus.out_data);
    else pass_cnt++;
    bus.in_valid = 1'b1;
    bus.in_data = 32'hDEAD_BEEF;
    step();
    step();
    resetn = 1'b1;
    step();
    total_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL rel_iready got %b want 1", bus.in_ready);
    else pass_cnt++;
    total_cnt++;
    if (bus.out_valid !== 1'b0) $display("FAIL rel_discard got %b want 0", bus.out_valid);
    else pass_cnt++;
    total_cnt++;
    if (bus.count !== 2'd0) $display("FAIL rel_count got %0d want 0", bus.count);
    else pass_cnt++;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_single;
    bus.in_valid = 1'b1;
    bus.in_data = 32'hA5A5_0001;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    total_cnt++;
    if (bus.out_valid !== 1'b1) $display("FAIL single_ovalid got %b want 1", bus.out_valid);
    else pass_cnt++;
    total_cnt++;
    if (bus.out_data !== 32'hA5A5_0001) $display("FAIL single_odata got %h want a5a50001", bus.out_data);
    else pass_cnt++;
    total_cnt++;
    if (bus.count !== 2'd1) $display("FAIL single_count got %0d want 1", bus.count);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.out_valid !== 1'b0) $display("FAIL single_drain got %b want 0", bus.out_valid);
    else pass_cnt++;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_fill;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 32'h11;
    step();
    total_cnt++;
    if (bus.count !== 2'd1) $display("FAIL fill_c1 got %0d want 1", bus.count);
    else pass_cnt++;
    bus.in_data = 32'h22;
    step();
    total_cnt++;
    if (bus.count !== 2'd2) $display("FAIL fill_c2 got %0d want 2", bus.count);
    else pass_cnt++;
    total_cnt++;
    if (bus.in_ready !== 1'b0) $display("FAIL fill_iready got %b want 0", bus.in_ready);
    else pass_cnt++;
    bus.in_data = 32'h33;
    step();
    bus.in_valid = 1'b0;
    total_cnt++;
    if (bus.count !== 2'd2) $display("FAIL fill_ignore got %0d want 2", bus.count);
    else pass_cnt++;
    total_cnt++;
    if (bus.out_data !== 32'h11) $display("FAIL fill_hold got %h want 11", bus.out_data);
    else pass_cnt++;
  endtask

  task automatic test_drain;
    bus.out_ready = 1'b1;
    step();
    total_cnt++;
    if (bus.out_data !== 32'h22) $display("FAIL drain_d2 got %h want 22", bus.out_data);
    else pass_cnt++;
    total_cnt++;
    if (bus.count !== 2'd1) $display("FAIL drain_c1 got %0d want 1", bus.count);
    else pass_cnt++;
    total_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL drain_iready got %b want 1", bus.in_ready);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.count !== 2'd0) $display("FAIL drain_c0 got %0d want 0", bus.count);
    else pass_cnt++;
    total_cnt++;
    if (bus.out_valid !== 1'b0) $display("FAIL drain_ovalid got %b want 0", bus.out_valid);
    else pass_cnt++;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_stream;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus.in_data = i;
      step();
      total_cnt++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'(i) || bus.in_ready !== 1'b1)
        $display("FAIL stream_%0d got v%b d%h r%b want v1 d%h r1",
                 i, bus.out_valid, bus.out_data, bus.in_ready, i);
      else pass_cnt++;
    end
    bus.in_valid = 1'b0;
    step();
    total_cnt++;
    if (bus.out_valid !== 1'b0) $display("FAIL stream_end got %b want 0", bus.out_valid);
    else pass_cnt++;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_random;
    logic [31:0] q[$];
    logic [31:0] seq = 32'h1000;
    logic [31:0] prev = '0;
    logic        stalled = 1'b0;
    logic        acc;
    logic        con;
    int          beats = 0;
    int          cyc = 0;
    while (beats < 10000 && cyc < 60000) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.in_data = seq;
      #1;
      acc = bus.in_valid && bus.in_ready;
      con = bus.out_valid && bus.out_ready;
      if (con) begin
        total_cnt++;
        if (q.size() == 0) $display("FAIL rnd_underflow got %h want none", bus.out_data);
        else if (bus.out_data !== q[0]) $display("FAIL rnd_data got %h want %h", bus.out_data, q[0]);
        else pass_cnt++;
        if (q.size() != 0) void'(q.pop_front());
        beats++;
      end
      stalled = bus.out_valid && !bus.out_ready;
      prev = bus.out_data;
      if (acc) begin
        q.push_back(seq);
        seq++;
      end
      step();
      cyc++;
      total_cnt++;
      if (bus.count !== 2'(q.size()) || bus.out_valid !== (q.size() != 0)
          || bus.in_ready !== (q.size() != 2))
        $display("FAIL rnd_state got c%0d v%b r%b want c%0d", bus.count,
                 bus.out_valid, bus.in_ready, q.size());
      else pass_cnt++;
      if (stalled) begin
        total_cnt++;
        if (bus.out_data !== prev || bus.out_valid !== 1'b1)
          $display("FAIL rnd_stable got %h want %h", bus.out_data, prev);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (beats < 10000) $display("FAIL rnd_timeout got %0d want 10000", beats);
    else pass_cnt++;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    bus.out_ready = 1'b0;
  endtask

`ifdef SKID_FLUSH_EN
  task automatic test_flush;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 32'hAA;
    step();
    bus.in_data = 32'hBB;
    step();
    total_cnt++;
    if (bus.count !== 2'd2) $display("FAIL flush_pre got %0d want 2", bus.count);
    else pass_cnt++;
    bus.flush = 1'b1;
    bus.in_data = 32'hCC;
    bus.out_ready = 1'b1;
    step();
    bus.flush = 1'b0;
    total_cnt++;
    if (bus.count !== 2'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL flush_state got c%0d v%b r%b want c0 v0 r1",
               bus.count, bus.out_valid, bus.in_ready);
    else pass_cnt++;
    bus.in_data = 32'hDD;
    step();
    bus.in_valid = 1'b0;
    total_cnt++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hDD)
      $display("FAIL flush_next got v%b d%h want v1 ddd", bus.out_valid, bus.out_data);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.out_valid !== 1'b0) $display("FAIL flush_tail got %b want 0", bus.out_valid);
    else pass_cnt++;
    bus.out_ready = 1'b0;
  endtask
`endif

  task automatic test_reset_mid;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 32'h5151;
    step();
    bus.in_data = 32'h6262;
    step();
    #2;
    resetn = 1'b0;
    #1;
    total_cnt++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.count !== 2'd0
        || bus.out_data !== 32'h0)
      $display("FAIL midrst got v%b r%b c%0d d%h want all 0",
               bus.out_valid, bus.in_ready, bus.count, bus.out_data);
    else pass_cnt++;
    step();
    resetn = 1'b1;
    bus.in_valid = 1'b0;
    step();
    total_cnt++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      $display("FAIL midrst_rel got r%b v%b want r1 v0", bus.in_ready, bus.out_valid);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_drain();
    test_stream();
    test_random();
`ifdef SKID_FLUSH_EN
    test_flush();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
